lamp_control_led: RTL and testbench



---
 rtl/lamp_control_led.sv | 134 +++++++++++++
 tb/tb_lamp_control_led.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lamp_control_led.sv
// Three-switch staircase lamp controller: lamp toggle, 7-seg switch code and change buzzer.
// Optional switch debounce is built when LAMP_DEBOUNCE_EN is defined.
module lamp_control_led #(
    parameter int unsigned BEEP_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S3,
    input  logic       S2,
    input  logic       S1,
    output logic       F,
    output logic       Buzzer,
    output logic [6:0] LED
);

    localparam int unsigned    BW        = $clog2(BEEP_CYCLES + 1);
    localparam logic [BW-1:0]  BEEP_LOAD = BW'(BEEP_CYCLES);
    localparam logic [BW-1:0]  BEEP_ONE  = BW'(1);
    localparam logic [6:0]     SEG_ZERO  = 7'b1000000;

    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    s;
    logic          f_q, f_d;
    logic [6:0]    led_q, led_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          buzz_q, buzz_d;

    function automatic logic [6:0] seg7(input logic [2:0] v);
        seg7 = SEG_ZERO;
        case (v)
            3'd0: seg7 = 7'b1000000;
            3'd1: seg7 = 7'b1111001;
            3'd2: seg7 = 7'b0100100;
            3'd3: seg7 = 7'b0110000;
            3'd4: seg7 = 7'b0011001;
            3'd5: seg7 = 7'b0010010;
            3'd6: seg7 = 7'b0000010;
            3'd7: seg7 = 7'b1111000;
            default: seg7 = SEG_ZERO;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {S3, S2, S1};
            sync2_q <= sync1_q;
        end
    end

`ifdef LAMP_DEBOUNCE_EN
    localparam int unsigned   DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    logic [2:0]    deb_q, deb_d;
    logic [DW-1:0] dcnt_q [3];
    logic [DW-1:0] dcnt_d [3];

    // A differing level must be seen DEBOUNCE_CYCLES clocks in a row; any match restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < 3; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DEB_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int unsigned i = 0; i < 3; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign s = deb_q;
`else
    // DEBOUNCE_CYCLES has no effect in this build.
    if (DEBOUNCE_CYCLES == 0) begin : g_deb_unused
    end

    assign s = sync2_q;
`endif

    // Buzzer is registered from the next counter value so it rises on the same edge as F.
    always_comb begin
        f_d   = ^s;
        led_d = seg7(s);
        if (f_d != f_q) begin
            beep_d = BEEP_LOAD;
        end else if (beep_q != '0) begin
            beep_d = beep_q - BEEP_ONE;
        end else begin
            beep_d = beep_q;
        end
        buzz_d = (beep_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= 1'b0;
            led_q  <= SEG_ZERO;
            beep_q <= '0;
            buzz_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            led_q  <= led_d;
            beep_q <= beep_d;
            buzz_q <= buzz_d;
        end
    end

    assign F      = f_q;
    assign LED    = led_q;
    assign Buzzer = buzz_q;

endmodule

// File: tb/tb_lamp_control_led.sv
// Scoreboard bench for lamp_control_led; define LAMP_DEBOUNCE_EN to exercise the debounce build.
module tb_lamp_control_led;

    localparam int unsigned B = 16;
    localparam int unsigned D = 8;
`ifdef LAMP_DEBOUNCE_EN
    localparam int unsigned LAT = 3 + D;
    localparam int unsigned GAP = D + 2;
`else
    localparam int unsigned LAT = 3;
    localparam int unsigned GAP = 5;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       S3, S2, S1;
    logic       F, Buzzer;
    logic [6:0] LED;

    lamp_control_led #(
        .BEEP_CYCLES     (B),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .S3     (S3),
        .S2     (S2),
        .S1     (S1),
        .F      (F),
        .Buzzer (Buzzer),
        .LED    (LED)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        string       tag;
        logic [8:0]  exp;
        logic [8:0]  mask;
    } exp_t;

    typedef struct {
        int unsigned start;
        int unsigned stop;
    } beep_t;

    exp_t        q[$];
    beep_t       beeps[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        mon_en = 1'b0;
    logic [2:0]  sw = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input logic [2:0] v);
        logic [6:0] tbl [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        return tbl[v];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned due, input string tag,
                             input logic f, input logic [2:0] code);
        exp_t e;
        e.due  = due;
        e.tag  = tag;
        e.exp  = {f, 1'b0, seg(code)};
        e.mask = 9'b101111111;
        q.push_back(e);
    endtask

    task automatic add_beep(input int unsigned due);
        beep_t b;
        b.start = due;
        b.stop  = due + B;
        beeps.push_back(b);
    endtask

    // Drive a new switch code and predict old outputs one clock before, new outputs at latency.
    task automatic apply(input logic [2:0] code, input string tag);
        int unsigned due;
        @(negedge clk);
        #1;
        due = cyc + LAT;
        {S3, S2, S1} = code;
        expect_at(due - 1, {tag, "_pre"}, ^sw, sw);
        expect_at(due, tag, ^code, code);
        if ((^code) != (^sw)) add_beep(due);
        sw = code;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic exp_b;
        if (mon_en && !rst) begin
            for (int i = int'(q.size()) - 1; i >= 0; i--) begin
                if (q[i].due == cyc) begin
                    check(q[i].tag, 32'({F, Buzzer, LED} & q[i].mask), 32'(q[i].exp & q[i].mask));
                    q.delete(i);
                end else if (q[i].due < cyc) begin
                    check({q[i].tag, "_late"}, q[i].due, cyc);
                    q.delete(i);
                end
            end
            while (beeps.size() != 0 && beeps[0].stop <= cyc) void'(beeps.pop_front());
            exp_b = 1'b0;
            foreach (beeps[i]) if (beeps[i].start <= cyc) exp_b = 1'b1;
            check("buzz", 32'(Buzzer), 32'(exp_b));
        end
    end

    initial begin
        int unsigned c;
        logic [2:0] walk [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        rst = 1'b1;
        {S3, S2, S1} = 3'b000;
        idle(3);
        #1;
        check("rst_f", 32'(F), 32'(0));
        check("rst_buzz", 32'(Buzzer), 32'(0));
        check("rst_led", 32'(LED), 32'(7'b1000000));
        rst = 1'b0;
        mon_en = 1'b1;
        c = cyc;
        expect_at(c + LAT, "rel_a", 1'b0, 3'b000);
        expect_at(c + LAT + 20, "rel_b", 1'b0, 3'b000);
        idle(30);

        foreach (walk[i]) begin
            apply(walk[i], $sformatf("walk%0d", i));
            idle(49);
        end

        apply(3'b001, "dbl_a");
        idle(40);
        apply(3'b010, "dbl_b");
        idle(40);

        apply(3'b011, "retrig_a");
        idle(GAP - 1);
        apply(3'b010, "retrig_b");
        idle(50);

        apply(3'b011, "edge_a");
        idle(B - 1);
        apply(3'b010, "edge_b");
        idle(50);

`ifdef LAMP_DEBOUNCE_EN
        apply(3'b000, "deb_pre");
        idle(40);
        @(negedge clk);
        #1;
        c = cyc;
        expect_at(c + 3, "glitch_a", 1'b0, 3'b000);
        expect_at(c + LAT, "glitch_b", 1'b0, 3'b000);
        expect_at(c + LAT + 6, "glitch_c", 1'b0, 3'b000);
        S2 = 1'b1;
        idle(D - 1);
        #1;
        S2 = 1'b0;
        idle(40);
        apply(3'b010, "deb_hold");
        idle(50);
`endif

        apply(3'b011, "t5_a");
        idle(40);
        apply(3'b001, "t5_b");
        idle(LAT + 2);
        #1;
        check("t5_pre_f", 32'(F), 32'(1));
        check("t5_pre_buzz", 32'(Buzzer), 32'(1));
        #2;
        rst = 1'b1;
        q.delete();
        beeps.delete();
        #1;
        check("t5_f", 32'(F), 32'(0));
        check("t5_buzz", 32'(Buzzer), 32'(0));
        check("t5_led", 32'(LED), 32'(7'b1000000));
        idle(3);
        #1;
        rst = 1'b0;
        c = cyc;
        expect_at(c + LAT - 1, "t5_rel_pre", 1'b0, 3'b000);
        expect_at(c + LAT, "t5_rel", 1'b1, 3'b001);
        add_beep(c + LAT);

        for (int i = 0; i < 300 && (q.size() != 0 || beeps.size() != 0); i++) @(negedge clk);
        check("drain", 32'(q.size() + beeps.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
